// File: rtl/disp_scan_scheduler.sv
// Six-digit multiplexed display driver: a two-requester frame buffer feeding a
// scan engine that serialises one digit per dwell period into two 74HC595s.
module disp_scan_scheduler #(
  parameter int SCK_DIV = 8,
  parameter int DWELL   = 5210
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       b_req,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       a_ack,
  output logic       b_ack,
  output logic       wr_err,
  input  logic       blank,
  output logic       databit,
  output logic       shcp,
  output logic       stcp,
  output logic       enable,
  output logic       busy,
  output logic [2:0] digit_idx
);

  localparam int FRAME_MIN = 33 * SCK_DIV + 1;
  localparam int DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int DWL_W     = $clog2(((DWELL > FRAME_MIN) ? DWELL : FRAME_MIN) + 2);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);
  localparam logic [DWL_W-1:0] DWELL_LAST = DWL_W'(DWELL - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DWL_W-1:0] DWL_ZERO   = {DWL_W{1'b0}};
  localparam bit SKIP_WAIT = (DWELL <= FRAME_MIN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_WAIT} state_t;

  logic [7:0]       frame_r [6];
  logic [2:0]       loss_r, loss_n_s;
  logic             grant_a_s, grant_b_s;
  logic [2:0]       wr_addr_s;
  logic [7:0]       wr_data_s;
  logic             a_ack_r, b_ack_r, wr_err_r;

  state_t           state_r, state_n;
  logic [DIV_W-1:0] div_r, div_n;
  logic             half_r, half_n;
  logic [3:0]       bit_r, bit_n;
  logic [DWL_W-1:0] dwell_r, dwell_n;
  logic [2:0]       digit_r, digit_n, digit_inc_s;
  logic [15:0]      word_r, word_n;
  logic             busy_r, shcp_r, stcp_r, databit_r, enable_r;

  // Grant selection; B's loss count tops out at 4 because the 4th loss forces a B win.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    loss_n_s  = loss_r;
    if (a_req && b_req) begin
      if (loss_r == 3'd4) begin
        grant_b_s = 1'b1;
        loss_n_s  = 3'd0;
      end else begin
        grant_a_s = 1'b1;
        loss_n_s  = loss_r + 3'd1;
      end
    end else if (a_req) begin
      grant_a_s = 1'b1;
    end else if (b_req) begin
      grant_b_s = 1'b1;
      loss_n_s  = 3'd0;
    end else begin
      grant_a_s = 1'b0;
    end
    wr_addr_s = grant_b_s ? b_addr : a_addr;
    wr_data_s = grant_b_s ? b_data : a_data;
  end

  // Frame buffer, ack pulses and loss counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) frame_r[i] <= 8'hFF;
      loss_r   <= 3'd0;
      a_ack_r  <= 1'b0;
      b_ack_r  <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      loss_r   <= loss_n_s;
      a_ack_r  <= grant_a_s;
      b_ack_r  <= grant_b_s;
      wr_err_r <= (grant_a_s || grant_b_s) && (wr_addr_s > 3'd5);
      if ((grant_a_s || grant_b_s) && (wr_addr_s <= 3'd5)) begin
        frame_r[wr_addr_s] <= wr_data_s;
      end else begin
        loss_r <= loss_n_s;
      end
    end
  end

  assign digit_inc_s = (digit_r == 3'd5) ? 3'd0 : digit_r + 3'd1;

  // Scan next-state; dwell_r counts cycles since LOAD entry.
  always_comb begin
    state_n = state_r;
    div_n   = div_r;
    half_n  = half_r;
    bit_n   = bit_r;
    dwell_n = dwell_r + 1'b1;
    digit_n = digit_r;
    word_n  = word_r;
    case (state_r)
      S_IDLE: begin
        state_n = S_LOAD;
        dwell_n = DWL_ZERO;
      end
      S_LOAD: begin
        state_n = S_SHIFT;
        word_n  = {6'b100000 >> digit_r, 2'b00, blank ? 8'hFF : frame_r[digit_r]};
        div_n   = DIV_ZERO;
        half_n  = 1'b0;
        bit_n   = 4'd0;
      end
      S_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_n = DIV_ZERO;
          if (half_r) begin
            half_n = 1'b0;
            if (bit_r == 4'd15) state_n = S_LATCH;
            else bit_n = bit_r + 4'd1;
          end else begin
            half_n = 1'b1;
          end
        end else begin
          div_n = div_r + 1'b1;
        end
      end
      S_LATCH: begin
        if (div_r == DIV_LAST) begin
          div_n = DIV_ZERO;
          if (SKIP_WAIT) begin
            state_n = S_LOAD;
            digit_n = digit_inc_s;
            dwell_n = DWL_ZERO;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          div_n = div_r + 1'b1;
        end
      end
      S_WAIT: begin
        if (dwell_r >= DWELL_LAST) begin
          state_n = S_LOAD;
          digit_n = digit_inc_s;
          dwell_n = DWL_ZERO;
        end else begin
          state_n = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Scan state register; pin outputs are registered from the next-state view so they align with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      div_r     <= DIV_ZERO;
      half_r    <= 1'b0;
      bit_r     <= 4'd0;
      dwell_r   <= DWL_ZERO;
      digit_r   <= 3'd0;
      word_r    <= 16'h0000;
      busy_r    <= 1'b0;
      shcp_r    <= 1'b0;
      stcp_r    <= 1'b0;
      databit_r <= 1'b0;
      enable_r  <= 1'b1;
    end else begin
      state_r   <= state_n;
      div_r     <= div_n;
      half_r    <= half_n;
      bit_r     <= bit_n;
      dwell_r   <= dwell_n;
      digit_r   <= digit_n;
      word_r    <= word_n;
      busy_r    <= (state_n == S_LOAD) || (state_n == S_SHIFT) || (state_n == S_LATCH);
      shcp_r    <= (state_n == S_SHIFT) && half_n;
      stcp_r    <= (state_n == S_LATCH);
      databit_r <= (state_n == S_SHIFT) && word_n[4'd15 - bit_n];
      if ((state_r == S_LATCH) && (state_n != S_LATCH)) enable_r <= 1'b0;
      else enable_r <= enable_r;
    end
  end

  assign a_ack     = a_ack_r;
  assign b_ack     = b_ack_r;
  assign wr_err    = wr_err_r;
  assign databit   = databit_r;
  assign shcp      = shcp_r;
  assign stcp      = stcp_r;
  assign enable    = enable_r;
  assign busy      = busy_r;
  assign digit_idx = digit_r;

endmodule

// File: tb/tb_disp_scan_scheduler.sv
// Directed bench for disp_scan_scheduler: scoreboard queues hold expected acks
// and frame words; outputs are sampled on the falling clock edge.
module tb_disp_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, blank = 1'b0;
  logic [2:0] a_addr = 3'd0, b_addr = 3'd0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ack, b_ack, wr_err, databit, shcp, stcp, enable, busy;
  logic [2:0] digit_idx;
  logic       d2_a_ack, d2_b_ack, d2_wr_err, d2_databit, d2_shcp, d2_stcp, d2_enable, d2_busy;
  logic [2:0] d2_digit;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0]  ack_q[$];
  logic [15:0] fw_q[$];
  logic [2:0]  fd_q[$];

  always #5 clk = ~clk;

  disp_scan_scheduler #(.SCK_DIV(1), .DWELL(40)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data),
    .a_ack(a_ack), .b_ack(b_ack), .wr_err(wr_err), .blank(blank),
    .databit(databit), .shcp(shcp), .stcp(stcp), .enable(enable),
    .busy(busy), .digit_idx(digit_idx)
  );

  // Short dwell: LOAD-to-LOAD spacing falls back to 33*SCK_DIV+1 = 67 cycles.
  disp_scan_scheduler #(.SCK_DIV(2), .DWELL(20)) dut2 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data),
    .a_ack(d2_a_ack), .b_ack(d2_b_ack), .wr_err(d2_wr_err), .blank(blank),
    .databit(d2_databit), .shcp(d2_shcp), .stcp(d2_stcp), .enable(d2_enable),
    .busy(d2_busy), .digit_idx(d2_digit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 32'({databit, shcp, stcp, a_ack, b_ack, wr_err, busy, enable, digit_idx}), 32'h008);
    chk({tag, "_d2"}, 32'({d2_databit, d2_shcp, d2_stcp, d2_a_ack, d2_b_ack, d2_wr_err,
                          d2_busy, d2_enable, d2_digit}), 32'h008);
  endtask

  // Capture one frame: shift bits on shcp rises, stop when stcp falls.
  task automatic grab(output logic [15:0] w, output int rises, output int stlen,
                      output logic [2:0] dig, output time t_rise);
    logic ps, pt;
    bit   done;
    w = 16'h0000; rises = 0; stlen = 0; dig = 3'd0; t_rise = 64'd0; done = 1'b0;
    ps = shcp; pt = stcp;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (shcp && !ps) begin w = {w[14:0], databit}; rises++; end
      if (stcp && !pt) begin t_rise = $time; dig = digit_idx; end
      if (stcp) stlen++;
      if (!stcp && pt) done = 1'b1;
      ps = shcp; pt = stcp;
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL frame_timeout observed=no stcp pulse expected=frame within 400 cycles");
    end
  endtask

  task automatic sync_after(input logic [2:0] target);
    logic [15:0] w; int r, s; logic [2:0] d; time t; bit hit;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      grab(w, r, s, d, t);
      if (d == target) hit = 1'b1;
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL sync_digit observed=not seen expected=digit %0d", target);
    end
  endtask

  task automatic rise2(output time t, output logic [2:0] d);
    logic pt; bit done;
    pt = d2_stcp; done = 1'b0; t = 64'd0; d = 3'd0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (d2_stcp && !pt) begin t = $time; d = d2_digit; done = 1'b1; end
      pt = d2_stcp;
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL d2_stcp_timeout observed=no rise expected=rise within 300 cycles");
    end
  endtask

  task automatic req_write(input bit use_b, input logic [2:0] addr, input logic [7:0] data,
                           input logic [2:0] exp_flags, input string tag);
    if (use_b) begin b_req = 1'b1; b_addr = addr; b_data = data; end
    else begin a_req = 1'b1; a_addr = addr; a_data = data; end
    ack_q.push_back(exp_flags);
    @(negedge clk);
    chk({tag, "_ack"}, 32'({a_ack, b_ack, wr_err}), 32'(ack_q.pop_front()));
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, 32'({a_ack, b_ack, wr_err}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=no finish expected=finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          r, s;
    logic [2:0]  d, d_prev;
    time         t, t_prev;
    logic        ps;
    logic [9:0]  a_pat;
    logic [15:0] exp_words [7];
    logic [2:0]  exp_digs [7];

    // Reset state
    @(negedge clk);
    chk_reset_outs("reset_outs");

    // Release with an A write of 8'h03 to digit 0 ahead of the first LOAD
    reset = 1'b0; a_req = 1'b1; a_addr = 3'd0; a_data = 8'h03;
    ack_q.push_back(3'b100);
    @(negedge clk);
    chk("first_ack", 32'({a_ack, b_ack, wr_err}), 32'(ack_q.pop_front()));
    chk("first_load", 32'({busy, digit_idx, enable}), 32'({1'b1, 3'd0, 1'b1}));
    a_req = 1'b0;
    @(negedge clk);
    chk("first_ack_drop", 32'({a_ack, b_ack, wr_err}), 32'h0);
    chk("enable_before_latch", 32'(enable), 32'h1);
    grab(w, r, s, d, t);
    chk("f0_word", 32'(w), 32'h8003);
    chk("f0_rises", 32'(r), 32'd16);
    chk("f0_stcp_len", 32'(s), 32'd1);
    chk("f0_digit", 32'(d), 32'd0);
    chk("f0_enable_after", 32'(enable), 32'h0);
    chk("f0_busy_wait", 32'(busy), 32'h0);

    // Continuous contention: A,A,A,A,B twice
    a_pat = 10'b1111011110;
    a_req = 1'b1; a_addr = 3'd1; a_data = 8'hA1;
    b_req = 1'b1; b_addr = 3'd3; b_data = 8'hB3;
    for (int k = 0; k < 10; k++) begin
      ack_q.push_back({a_pat[9-k], ~a_pat[9-k], 1'b0});
      @(negedge clk);
      chk("contend", 32'({a_ack, b_ack, wr_err}), 32'(ack_q.pop_front()));
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("contend_drop", 32'({a_ack, b_ack, wr_err}), 32'h0);

    req_write(1'b0, 3'd2, 8'h25, 3'b100, "a_addr2");
    req_write(1'b1, 3'd7, 8'h00, 3'b011, "b_addr7");
    req_write(1'b0, 3'd6, 8'h00, 3'b101, "a_addr6");

    // Blank forced at digit 2's LOAD
    sync_after(3'd1);
    blank = 1'b1;
    grab(w, r, s, d, t);
    chk("blank_word", 32'(w), 32'h20FF);
    chk("blank_digit", 32'(d), 32'd2);
    blank = 1'b0;

    // Seven consecutive frames starting at digit 0
    exp_words = '{16'h8003, 16'h40A1, 16'h2025, 16'h10B3, 16'h08FF, 16'h04FF, 16'h8003};
    exp_digs  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    for (int i = 0; i < 7; i++) begin
      fw_q.push_back(exp_words[i]);
      fd_q.push_back(exp_digs[i]);
    end
    sync_after(3'd5);
    t_prev = 64'd0;
    for (int i = 0; i < 7; i++) begin
      grab(w, r, s, d, t);
      chk("seq_word", 32'(w), 32'(fw_q.pop_front()));
      chk("seq_digit", 32'(d), 32'(fd_q.pop_front()));
      if (i > 0) chk("load_spacing", 32'(t - t_prev), 32'd400);
      t_prev = t;
    end

    // Short-dwell instance: spacing clamps to 67 cycles, digit steps by one
    rise2(t_prev, d_prev);
    rise2(t, d);
    chk("d2_spacing", 32'(t - t_prev), 32'd670);
    chk("d2_digit_step", 32'(d), 32'((d_prev == 3'd5) ? 3'd0 : d_prev + 3'd1));

    // Reset during bit 9 of SHIFT
    grab(w, r, s, d, t);
    r = 0; ps = shcp;
    for (int n = 0; n < 200 && r < 9; n++) begin
      @(negedge clk);
      if (shcp && !ps) r++;
      ps = shcp;
    end
    @(negedge clk);
    chk("pre_reset_busy", 32'({busy, shcp}), 32'h2);
    reset = 1'b1;
    #1;
    chk_reset_outs("midshift_reset");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("reset_hold");
    reset = 1'b0;
    #1;
    chk("post_reset_idle", 32'({busy, stcp}), 32'h0);
    @(negedge clk);
    chk("post_reset_load", 32'({busy, stcp, enable, digit_idx}), 32'({1'b1, 1'b0, 1'b1, 3'd0}));
    grab(w, r, s, d, t);
    chk("post_reset_word", 32'(w), 32'h80FF);
    chk("post_reset_rises", 32'(r), 32'd16);
    chk("post_reset_stcp_len", 32'(s), 32'd1);
    chk("post_reset_digit", 32'(d), 32'd0);
    chk("post_reset_enable", 32'(enable), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
